// File: rtl/cmos_i2c.sv
// cmos_i2c: I2C slave that behaves like the PCF8583 CMOS RAM (256 bytes). It also
// has a host side port that preloads and reads back the image and flags guest writes.
module cmos_i2c #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         FILTER   = 4
) (
  input  logic       clkcpu,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  input  logic       cfg_we,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_din,
  output logic [7:0] cfg_dout,
  output logic       dirty,
  input  logic       dirty_clr
);

  localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_SUB, S_SUB_ACK,
    S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
  } state_t;

  // ---------------- input conditioning (index 1 = SCL, 0 = SDA) ----------------
  logic [1:0] line_raw, line_f;
  assign line_raw = {scl_i, sda_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cond
    logic          sync1_q, sync2_q, filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // accept a new level only after FILTER consecutive samples that differ from the current one
    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
        if (cnt_q == CW'(FILTER - 1)) filt_d = sync2_q;
        else                          cnt_d  = cnt_q + CW'(1);
      end
    end

    // two-flop synchroniser and filter state; the idle bus level is 1
    always_ff @(posedge clkcpu) begin
      if (rst_i) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        filt_q  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= line_raw[gi];
        sync2_q <= sync1_q;
        filt_q  <= filt_d;
        cnt_q   <= cnt_d;
      end
    end

    assign line_f[gi] = filt_q;
  end

  logic scl_f, sda_f, scl_prev_q, sda_prev_q;
  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_f    = line_f[1];
  assign sda_f    = line_f[0];
  assign scl_rise = scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f & scl_prev_q;
  assign start_ev = scl_f & sda_prev_q & ~sda_f;
  assign stop_ev  = scl_f & ~sda_prev_q & sda_f;

  // ---------------- protocol state ----------------
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, ptr_q, ptr_d, byte_in, rd_data_q, cfg_dout_q;
  logic       rw_q, rw_d, drive_q, drive_d, wr_req;

  assign byte_in = {shift_q[6:0], sda_f};

  // next-state logic: data is taken on SCL rise, the slave changes its drive only on SCL fall
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    drive_d   = drive_q;
    wr_req    = 1'b0;
    if (start_ev) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      drive_d   = 1'b0;
    end else if (stop_ev) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      drive_d   = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR, S_SUB, S_WR: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == S_ADDR) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                state_d = S_ADDR_ACK;
                rw_d    = byte_in[0];
              end else begin
                state_d = S_IGNORE;
              end
            end else if (state_q == S_SUB) begin
              ptr_d   = byte_in;
              state_d = S_SUB_ACK;
            end else begin
              wr_req  = 1'b1;
              ptr_d   = ptr_q + 8'd1;
              state_d = S_WR_ACK;
            end
          end
        end
        S_ADDR_ACK: begin
          bit_cnt_d = '0;
          if (rw_q) begin
            state_d = S_RD;
            shift_d = rd_data_q;
          end else begin
            state_d = S_SUB;
          end
        end
        S_SUB_ACK, S_WR_ACK: begin
          bit_cnt_d = '0;
          state_d   = S_WR;
        end
        S_RD: begin
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_RD_ACK;
            ptr_d   = ptr_q + 8'd1;
          end
        end
        S_RD_ACK: begin
          bit_cnt_d = '0;
          if (!sda_f) begin
            state_d = S_RD;
            shift_d = rd_data_q;
          end else begin
            state_d = S_IGNORE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR_ACK, S_SUB_ACK, S_WR_ACK: drive_d = 1'b1;
        S_RD:                            drive_d = ~shift_q[7];
        default:                         drive_d = 1'b0;
      endcase
    end
  end

  // ---------------- RAM write arbitration ----------------
  logic       pend_q, pend_d, commit, mem_we, dirty_q, dirty_d;
  logic [7:0] pend_addr_q, pend_addr_d, pend_data_q, pend_data_d, mem_waddr, mem_wdata;

  // the host owns the write port while cfg_we is high, and a colliding I2C byte waits in pend
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    commit      = 1'b0;
    mem_we      = cfg_we;
    mem_waddr   = cfg_addr;
    mem_wdata   = cfg_din;
    if (cfg_we) begin
      if (wr_req) begin
        pend_d      = 1'b1;
        pend_addr_d = ptr_q;
        pend_data_d = byte_in;
      end
    end else if (pend_q) begin
      commit    = 1'b1;
      mem_we    = 1'b1;
      mem_waddr = pend_addr_q;
      mem_wdata = pend_data_q;
      pend_d    = 1'b0;
    end else if (wr_req) begin
      commit    = 1'b1;
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = byte_in;
    end
    dirty_d = commit | (dirty_q & ~dirty_clr);
  end

  // control registers
  always_ff @(posedge clkcpu) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      drive_q     <= 1'b0;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      dirty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      drive_q     <= drive_d;
      scl_prev_q  <= scl_f;
      sda_prev_q  <= sda_f;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      dirty_q     <= dirty_d;
    end
  end

  // 256-byte RAM: one write port, registered reads for the host and for the I2C pointer
  logic [7:0] mem [256];
  always_ff @(posedge clkcpu) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    cfg_dout_q <= mem[cfg_addr];
    rd_data_q  <= mem[ptr_q];
  end

  assign sda_o    = sda_i & ~drive_q;
  assign cfg_dout = cfg_dout_q;
  assign dirty    = dirty_q;

endmodule

// File: tb/tb_cmos_i2c.sv
// tb_cmos_i2c: bit-banged I2C master and host-port driver, checked against a byte-array model
module tb_cmos_i2c;
  localparam int H = 12;

  logic       clkcpu = 1'b0;
  logic       rst_i, scl_i, sda_i, sda_o, cfg_we, dirty, dirty_clr;
  logic [7:0] cfg_addr, cfg_din, cfg_dout;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem_m [256];
  logic [7:0] ptr_m;
  logic [7:0] wbuf [4];

  cmos_i2c dut (
    .clkcpu   (clkcpu),
    .rst_i    (rst_i),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_o    (sda_o),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_din  (cfg_din),
    .cfg_dout (cfg_dout),
    .dirty    (dirty),
    .dirty_clr(dirty_clr)
  );

  always #5 clkcpu = ~clkcpu;

  task automatic tick(input int n);
    repeat (n) @(posedge clkcpu);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {7'b0, obs}, {7'b0, exp});
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
    tick(1);
    cfg_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic cfg_rd(input logic [7:0] a, output logic [7:0] d);
    cfg_addr = a;
    tick(1);
    d = cfg_dout;
  endtask

  task automatic clr_dirty();
    dirty_clr = 1'b1;
    tick(1);
    dirty_clr = 1'b0;
  endtask

  task automatic i2c_start();
    sda_i = 1'b1; tick(H);
    scl_i = 1'b1; tick(H);
    sda_i = 1'b0; tick(H);
    scl_i = 1'b0; tick(H);
  endtask

  task automatic i2c_stop();
    sda_i = 1'b0; tick(H);
    scl_i = 1'b1; tick(H);
    sda_i = 1'b1; tick(H);
  endtask

  // master releases SDA and samples the bus near the end of the SCL high phase
  task automatic bit_r(output logic b);
    sda_i = 1'b1; tick(H);
    scl_i = 1'b1; tick(H);
    b = sda_o;
    scl_i = 1'b0; tick(H);
  endtask

  // glitch: short inverted SDA pulse mid-high on the MSB; collide: host write to 0x20 during the last bit
  task automatic byte_w(input logic [7:0] d, input bit glitch, input bit collide,
                        input logic [7:0] cdata, output logic ack_lvl);
    for (int i = 7; i >= 0; i--) begin
      sda_i = d[i]; tick(H);
      scl_i = 1'b1;
      if (collide && i == 0) begin
        cfg_we = 1'b1; cfg_addr = 8'h20; cfg_din = cdata;
      end
      tick(H / 2);
      if (glitch && i == 7) begin
        sda_i = ~d[i]; tick(2); sda_i = d[i];
      end
      tick(H / 2);
      cfg_we = 1'b0;
      scl_i = 1'b0; tick(H);
    end
    bit_r(ack_lvl);
  endtask

  task automatic byte_r(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    sda_i = mack; tick(H);
    scl_i = 1'b1; tick(H);
    chk1("rd_ack_slot_released", sda_o, mack);
    scl_i = 1'b0; tick(H);
  endtask

  task automatic i2c_write(input logic [7:0] sub, input int n, input bit glitch,
                           input bit collide, input logic [7:0] cdata);
    logic a;
    i2c_start();
    byte_w(8'hA0, 1'b0, 1'b0, cdata, a); chk1("wr_addr_ack", a, 1'b0);
    byte_w(sub, 1'b0, 1'b0, cdata, a);   chk1("wr_sub_ack", a, 1'b0);
    ptr_m = sub;
    for (int i = 0; i < n; i++) begin
      byte_w(wbuf[i], glitch, collide && (i == n - 1), cdata, a);
      chk1("wr_data_ack", a, 1'b0);
      mem_m[ptr_m] = wbuf[i];
      ptr_m = ptr_m + 8'd1;
    end
    if (collide) mem_m[8'h20] = cdata;
    i2c_stop();
    $display("txn write sub=%02h n=%0d glitch=%0d collide=%0d", sub, n, glitch, collide);
  endtask

  task automatic i2c_read(input bit use_sub, input logic [7:0] sub, input int n);
    logic a;
    logic [7:0] d;
    if (use_sub) begin
      i2c_start();
      byte_w(8'hA0, 1'b0, 1'b0, 8'h00, a); chk1("rd_waddr_ack", a, 1'b0);
      byte_w(sub, 1'b0, 1'b0, 8'h00, a);   chk1("rd_sub_ack", a, 1'b0);
      ptr_m = sub;
    end
    i2c_start();
    byte_w(8'hA1, 1'b0, 1'b0, 8'h00, a); chk1("rd_addr_ack", a, 1'b0);
    for (int i = 0; i < n; i++) begin
      byte_r((i == n - 1) ? 1'b1 : 1'b0, d);
      chk("rd_data", d, mem_m[ptr_m]);
      ptr_m = ptr_m + 8'd1;
    end
    i2c_stop();
    chk1("rd_released_after_stop", sda_o, 1'b1);
    $display("txn read sub=%02h use_sub=%0d n=%0d ptr_after=%02h", sub, use_sub, n, ptr_m);
  endtask

  initial begin
    logic       a;
    logic [7:0] d, sub, cd;
    int         n;

    rst_i = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
    cfg_we = 1'b0; cfg_addr = 8'h00; cfg_din = 8'h00; dirty_clr = 1'b0;
    ptr_m = 8'h00;
    tick(4);
    rst_i = 1'b0;
    tick(8);
    chk1("reset_sda_released", sda_o, 1'b1);
    chk1("reset_dirty", dirty, 1'b0);

    // host preload of the whole image
    for (int i = 0; i < 256; i++) begin
      cfg_wr(8'(i), 8'($urandom));
    end
    chk1("preload_no_dirty", dirty, 1'b0);
    $display("txn preload 256 bytes");

    // write and read-back
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
    i2c_write(8'h10, 2, 1'b0, 1'b0, 8'h00);
    chk1("write_dirty_set", dirty, 1'b1);
    cfg_rd(8'h10, d); chk("cfg_rd_10", d, mem_m[8'h10]);
    cfg_rd(8'h11, d); chk("cfg_rd_11", d, mem_m[8'h11]);

    // random read with repeated START; a current-address read then shows where ptr ended
    cfg_wr(8'h40, 8'h12); cfg_wr(8'h41, 8'h34);
    i2c_read(1'b1, 8'h40, 2);
    i2c_read(1'b0, 8'h00, 1);

    // wrong device address
    clr_dirty();
    chk1("dirty_cleared", dirty, 1'b0);
    i2c_start();
    byte_w(8'hA2, 1'b0, 1'b0, 8'h00, a); chk1("wrong_addr_noack0", a, 1'b1);
    byte_w(8'h00, 1'b0, 1'b0, 8'h00, a); chk1("wrong_addr_noack1", a, 1'b1);
    byte_w(8'hFF, 1'b0, 1'b0, 8'h00, a); chk1("wrong_addr_noack2", a, 1'b1);
    i2c_stop();
    $display("txn wrong address 0xA2");
    chk1("wrong_addr_dirty", dirty, 1'b0);
    cfg_rd(8'h00, d); chk("wrong_addr_mem00", d, mem_m[8'h00]);
    cfg_rd(8'hFF, d); chk("wrong_addr_memff", d, mem_m[8'hFF]);

    // pointer wrap on write (with a glitch on each data MSB) and on read
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    i2c_write(8'hFF, 2, 1'b1, 1'b0, 8'h00);
    cfg_rd(8'hFF, d); chk("wrap_memff", d, mem_m[8'hFF]);
    cfg_rd(8'h00, d); chk("wrap_mem00", d, mem_m[8'h00]);
    i2c_read(1'b1, 8'hFF, 2);

    // reset while the slave drives a 0 data bit
    cfg_wr(8'h77, 8'h35);
    i2c_start();
    byte_w(8'hA0, 1'b0, 1'b0, 8'h00, a); chk1("rst_rd_waddr_ack", a, 1'b0);
    byte_w(8'h77, 1'b0, 1'b0, 8'h00, a); chk1("rst_rd_sub_ack", a, 1'b0);
    i2c_start();
    byte_w(8'hA1, 1'b0, 1'b0, 8'h00, a); chk1("rst_rd_addr_ack", a, 1'b0);
    chk1("rst_rd_driving_msb0", sda_o, 1'b0);
    rst_i = 1'b1;
    tick(1);
    chk1("rst_released_next_cycle", sda_o, 1'b1);
    rst_i = 1'b0;
    ptr_m = 8'h00;
    chk1("rst_dirty_cleared", dirty, 1'b0);
    for (int i = 0; i < 9; i++) begin
      bit_r(a);
      chk1("rst_no_drive", a, 1'b1);
    end
    i2c_stop();
    $display("txn reset mid-read");
    i2c_read(1'b0, 8'h00, 1);

    // host write to 0x20 collides with the I2C commit to 0x21
    wbuf[0] = 8'($urandom);
    cd = 8'($urandom);
    i2c_write(8'h21, 1, 1'b1, 1'b1, cd);
    cfg_rd(8'h20, d); chk("collide_mem20", d, mem_m[8'h20]);
    cfg_rd(8'h21, d); chk("collide_mem21", d, mem_m[8'h21]);
    chk1("collide_dirty", dirty, 1'b1);

    // randomized multi-byte writes with read-back over both ports
    for (int t = 0; t < 4; t++) begin
      sub = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      clr_dirty();
      i2c_write(sub, n, 1'b0, 1'b0, 8'h00);
      chk1("rand_dirty", dirty, 1'b1);
      for (int i = 0; i < n; i++) begin
        cfg_rd(sub + 8'(i), d);
        chk("rand_cfg_rd", d, mem_m[sub + 8'(i)]);
      end
      i2c_read(1'b1, sub, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
